apb_arbiter: RTL and testbench
==============================

// Module: apb_arbiter
// PURPOSE
//  Two-initiator APB4 arbiter sitting in front of apb_fabric. It lets the core and a
//  second bus master (DMA or debug) share the one fabric/target path.
//  Transfers are granted round-robin. Each granted transfer is re-issued on the
//  downstream port as a complete SETUP/ACCESS sequence, and the response is returned
//  only to the winner.
// PARAMETERS
//  ADDR_W   34   address width on all three APB ports (matches the core paddr)
// PORTS
//  clk                 input   1       clock
//  rst_n               input   1       synchronous active-low reset
//  i0_/i1_psel         input   1       initiator select (i0 = core, i1 = second master)
//  i0_/i1_penable      input   1       initiator enable (ignored for arbitration)
//  i0_/i1_paddr        input   ADDR_W  initiator address
//  i0_/i1_pwrite       input   1       initiator write flag
//  i0_/i1_pwdata       input   32      initiator write data
//  i0_/i1_pwstrb       input   4       initiator byte strobes
//  i0_/i1_pready       output  1       transfer complete, to initiator
//  i0_/i1_prdata       output  32      read data, to initiator
//  i0_/i1_pslverr      output  1       error, to initiator
//  t_psel, t_penable   output  1       downstream select / enable (to fabric)
//  t_paddr             output  ADDR_W  downstream address
//  t_pwrite            output  1       downstream write flag
//  t_pwdata            output  32      downstream write data
//  t_pwstrb            output  4       downstream byte strobes
//  t_pready            input   1       downstream ready
//  t_prdata            input   32      downstream read data
//  t_pslverr           input   1       downstream error
// BEHAVIOUR
//  FSM states: IDLE, SETUP, ACCESS. State and grant are registered.
//  Reset (rst_n=0 at a clk edge):
//   - state <= IDLE; rr_last <= 1, so i0 wins the first tie.
//   - All t_* registered outputs <= 0.
//   - Any in-flight transfer is abandoned: no pready is returned for it.
//  Outputs during reset and in IDLE:
//   - t_psel = t_penable = 0.
//   - All iN_pready/prdata/pslverr = 0.
//  IDLE:
//   - A request is iN_psel=1.
//   - No request: stay in IDLE.
//   - One request: grant it.
//   - Both request: grant the one not equal to rr_last.
//   - On a grant: register grant index; latch the winner's paddr/pwrite/pwdata/pwstrb
//     into t_*; set t_psel=1, t_penable=0; go to SETUP.
//  SETUP:
//   - t_penable <= 1; go to ACCESS (exactly one cycle).
//  ACCESS, held while t_pready=0:
//   - t_* outputs stay stable (APB wait states).
//  ACCESS, completion cycle (t_pready=1):
//   - Combinational iG_pready=1; iG_prdata=t_prdata; iG_pslverr=t_pslverr (G = granted).
//   - The non-granted initiator sees 0 on all three response outputs.
//   - Next edge: t_psel <= 0, t_penable <= 0, rr_last <= G, state <= IDLE.
//  Initiator side:
//   - The arbiter never returns pready to an initiator it has not granted.
//   - A loser simply sees wait states; its request stays pending, since APB holds psel
//     and the payload stable until pready.
//  Latency:
//   - Minimum 3 cycles from psel to pready (IDLE sample, SETUP, ACCESS), plus the
//     downstream wait states.
//   - Back-to-back transfers have one IDLE cycle between them.
//  Fairness:
//   - With both requesting continuously, grants alternate i0,i1,i0,...
//   - No initiator waits more than one foreign transfer.
//  Write data is latched at grant. prdata and pslverr are pass-through, not registered.
//  Illegal input (penable=1 without a prior psel setup) is still treated as a request.
// TESTING
//  1. i0 read addr 0x0_8000_0010, t_pready=1 at first ACCESS, t_prdata=0xDEADBEEF
//     -> t_psel rises 1 cycle after i0_psel and t_penable the cycle after;
//     i0_pready=1 with prdata=0xDEADBEEF on the 3rd cycle; i1_pready stays 0.
//  2. i0 and i1 assert psel in the same cycle, from reset
//     -> i0 served first and i1 next; with both re-requesting, grant order is
//     i0,i1,i0,i1 over 4 transfers.
//  3. i1 write 0x1234_5678, pwstrb=0x3, downstream holds t_pready=0 for 5 ACCESS cycles
//     -> t_paddr/t_pwdata/t_pwstrb stable for all 5; i1_pready pulses for 1 cycle when
//     t_pready=1.
//  4. t_pslverr=1 on completion of an i0 transfer
//     -> i0_pslverr=1 in the same cycle as i0_pready; i1_pslverr=0.
//  5. rst_n=0 in ACCESS with t_pready=0
//     -> next cycle: state IDLE, t_psel=t_penable=0, no pready to either initiator;
//     a tie right after reset grants i0.

Source files
------------

// File: rtl/apb_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_arbiter_if
//   One APB4 requester/completer port bundle. The arbiter uses the slave view
//   for each of its two initiator ports and the master view for its single
//   downstream (fabric) port.
//
//   Request side  : psel, penable, paddr[ADDR_W], pwrite, pwdata[32], pwstrb[4]
//   Response side : pready, prdata[32], pslverr
// -----------------------------------------------------------------------------
interface apb_arbiter_if #(
  parameter int ADDR_W = 34
);
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pwstrb;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  // Drives a transfer and waits for the response.
  modport master (
    output psel, penable, paddr, pwrite, pwdata, pwstrb,
    input  pready, prdata, pslverr
  );

  // Accepts a transfer and returns the response.
  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pwstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
//   Two-initiator APB4 arbiter in front of the fabric. Requests (psel=1) are
//   granted round-robin; the winner's transfer is replayed downstream as a full
//   SETUP/ACCESS sequence and the completion is routed back to the winner only.
//
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   i0     : initiator 0 (core), slave view
//   i1     : initiator 1 (DMA / debug), slave view
//   t      : downstream port to the fabric, master view
// -----------------------------------------------------------------------------
module apb_arbiter #(
  parameter int ADDR_W = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  apb_arbiter_if.slave  i0,
  apb_arbiter_if.slave  i1,
  apb_arbiter_if.master t
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic              gnt_q,       gnt_d;      // 0 = i0, 1 = i1
  logic              rr_last_q,   rr_last_d;  // initiator served last
  logic              t_psel_q,    t_psel_d;
  logic              t_penable_q, t_penable_d;
  logic [ADDR_W-1:0] t_paddr_q,   t_paddr_d;
  logic              t_pwrite_q,  t_pwrite_d;
  logic [31:0]       t_pwdata_q,  t_pwdata_d;
  logic [3:0]        t_pwstrb_q,  t_pwstrb_d;

  logic req0, req1, done;

  // Initiator penable plays no part in arbitration: a psel alone is a request.
  logic unused_penable;
  assign unused_penable = i0.penable ^ i1.penable;

  assign req0 = i0.psel;
  assign req1 = i1.psel;

  // Completion cycle of the granted transfer; suppressed while reset is held
  // so an abandoned transfer never signals pready.
  assign done = rst_n && (state_q == ACCESS) && t.pready;

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // branch below leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    t_psel_d    = t_psel_q;
    t_penable_d = t_penable_q;
    t_paddr_d   = t_paddr_q;
    t_pwrite_d  = t_pwrite_q;
    t_pwdata_d  = t_pwdata_q;
    t_pwstrb_d  = t_pwstrb_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the initiator not served last wins; otherwise the sole
          // requester wins (req1 alone -> 1, req0 alone -> 0).
          gnt_d = (req0 && req1) ? ~rr_last_q : req1;
          if (gnt_d) begin
            t_paddr_d  = i1.paddr;
            t_pwrite_d = i1.pwrite;
            t_pwdata_d = i1.pwdata;
            t_pwstrb_d = i1.pwstrb;
          end else begin
            t_paddr_d  = i0.paddr;
            t_pwrite_d = i0.pwrite;
            t_pwdata_d = i0.pwdata;
            t_pwstrb_d = i0.pwstrb;
          end
          t_psel_d    = 1'b1;
          t_penable_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        t_penable_d = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        // Payload is held untouched through downstream wait states.
        if (t.pready) begin
          t_psel_d    = 1'b0;
          t_penable_d = 1'b0;
          rr_last_d   = gnt_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        t_psel_d    = 1'b0;
        t_penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      t_psel_q    <= 1'b0;
      t_penable_q <= 1'b0;
      // NOTE: the payload registers are reset as well, so the downstream
      // address/data read as zero after reset instead of stale values.
      t_paddr_q   <= '0;
      t_pwrite_q  <= 1'b0;
      t_pwdata_q  <= '0;
      t_pwstrb_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      t_psel_q    <= t_psel_d;
      t_penable_q <= t_penable_d;
      t_paddr_q   <= t_paddr_d;
      t_pwrite_q  <= t_pwrite_d;
      t_pwdata_q  <= t_pwdata_d;
      t_pwstrb_q  <= t_pwstrb_d;
    end
  end

  // Downstream select/enable are forced low while reset is held.
  assign t.psel    = t_psel_q & rst_n;
  assign t.penable = t_penable_q & rst_n;
  assign t.paddr   = t_paddr_q;
  assign t.pwrite  = t_pwrite_q;
  assign t.pwdata  = t_pwdata_q;
  assign t.pwstrb  = t_pwstrb_q;

  // Response is combinational pass-through, steered to the granted side only.
  assign i0.pready  = done & ~gnt_q;
  assign i0.prdata  = (done & ~gnt_q) ? t.prdata : 32'h0;
  assign i0.pslverr = done & ~gnt_q & t.pslverr;
  assign i1.pready  = done & gnt_q;
  assign i1.prdata  = (done & gnt_q) ? t.prdata : 32'h0;
  assign i1.pslverr = done & gnt_q & t.pslverr;

endmodule

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
//   Self-checking bench for apb_arbiter: directed scenarios with literal
//   expectations, then randomized traffic checked every cycle against a
//   transaction-level model of the arbiter.
// -----------------------------------------------------------------------------
module tb_apb_arbiter;

  localparam int ADDR_W = 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Initiator-side stimulus, indexed by initiator.
  logic [1:0]        psel_v    = '0;
  logic [1:0]        penable_v = '0;
  logic [1:0]        pwrite_v  = '0;
  logic [ADDR_W-1:0] paddr_v  [2];
  logic [31:0]       pwdata_v [2];
  logic [3:0]        pwstrb_v [2];

  // Fabric-side stimulus.
  logic        t_pready_v  = 1'b0;
  logic [31:0] t_prdata_v  = '0;
  logic        t_pslverr_v = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  apb_arbiter_if #(.ADDR_W(ADDR_W)) i0_bus ();
  apb_arbiter_if #(.ADDR_W(ADDR_W)) i1_bus ();
  apb_arbiter_if #(.ADDR_W(ADDR_W)) t_bus ();

  assign i0_bus.psel    = psel_v[0];
  assign i0_bus.penable = penable_v[0];
  assign i0_bus.paddr   = paddr_v[0];
  assign i0_bus.pwrite  = pwrite_v[0];
  assign i0_bus.pwdata  = pwdata_v[0];
  assign i0_bus.pwstrb  = pwstrb_v[0];
  assign i1_bus.psel    = psel_v[1];
  assign i1_bus.penable = penable_v[1];
  assign i1_bus.paddr   = paddr_v[1];
  assign i1_bus.pwrite  = pwrite_v[1];
  assign i1_bus.pwdata  = pwdata_v[1];
  assign i1_bus.pwstrb  = pwstrb_v[1];
  assign t_bus.pready   = t_pready_v;
  assign t_bus.prdata   = t_prdata_v;
  assign t_bus.pslverr  = t_pslverr_v;

  apb_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (i0_bus),
    .i1    (i1_bus),
    .t     (t_bus)
  );

  always #5 clk = ~clk;

  logic [1:0]  rdy_o;
  logic [1:0]  err_o;
  logic [31:0] rd_o [2];
  assign rdy_o = {i1_bus.pready, i0_bus.pready};
  assign err_o = {i1_bus.pslverr, i0_bus.pslverr};
  assign rd_o[0] = i0_bus.prdata;
  assign rd_o[1] = i1_bus.prdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the downstream bus, for how many cycles, and the
  // payload captured when ownership was taken. Cycle 1 of ownership is the
  // setup phase, cycle 2 onward the access phase that ends on fabric ready.
  // ---------------------------------------------------------------------------
  int                m_owner = -1;
  int                m_age   = 0;
  int                m_last  = 1;
  logic [ADDR_W-1:0] m_addr;
  logic              m_wr;
  logic [31:0]       m_wd;
  logic [3:0]        m_st;

  logic        e_psel, e_pen;
  logic [1:0]  e_rdy, e_err;
  logic [31:0] e_rd [2];

  // Observations from the DUT, used by the stimulus and the fairness check.
  logic [1:0] dut_rdy = '0;
  int         dut_log[$];
  int         foreign[2] = '{0, 0};

  always @(negedge clk) begin
    int w;
    e_psel = 1'b0;
    e_pen  = 1'b0;
    e_rdy  = '0;
    e_err  = '0;
    e_rd[0] = '0;
    e_rd[1] = '0;
    if (rst_n && m_owner >= 0) begin
      e_psel = 1'b1;
      e_pen  = (m_age >= 2);
      if (m_age >= 2 && t_pready_v) begin
        e_rdy[m_owner] = 1'b1;
        e_err[m_owner] = t_pslverr_v;
        e_rd[m_owner]  = t_prdata_v;
      end
    end

    check("m_t_psel",    t_bus.psel,    e_psel);
    check("m_t_penable", t_bus.penable, e_pen);
    check("m_i0_pready", rdy_o[0], e_rdy[0]);
    check("m_i1_pready", rdy_o[1], e_rdy[1]);
    check("m_i0_prdata", rd_o[0], e_rd[0]);
    check("m_i1_prdata", rd_o[1], e_rd[1]);
    check("m_i0_pslverr", err_o[0], e_err[0]);
    check("m_i1_pslverr", err_o[1], e_err[1]);
    if (rst_n && m_owner >= 0) begin
      check("m_t_paddr",  t_bus.paddr,  m_addr);
      check("m_t_pwrite", t_bus.pwrite, m_wr);
      check("m_t_pwdata", t_bus.pwdata, m_wd);
      check("m_t_pwstrb", t_bus.pwstrb, m_st);
    end

    // Fairness as seen on the DUT: a waiting initiator may watch at most one
    // other transfer complete before its own completes.
    dut_rdy = rdy_o;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || !psel_v[k]) begin
        foreign[k] = 0;
      end else if (rdy_o[1-k]) begin
        foreign[k]++;
      end
      if (rdy_o[k]) begin
        dut_log.push_back(k);
        vectors++;
        if (foreign[k] > 1) begin
          miscompares++;
          $display("FAIL fair_wait i%0d: waited %0d foreign transfers, limit 1", k, foreign[k]);
        end
        foreign[k] = 0;
      end
    end

    // Advance the model with the inputs the DUT samples at the coming edge.
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 1;
    end else if (m_owner < 0) begin
      w = -1;
      if (psel_v[0] && psel_v[1]) w = 1 - m_last;
      else if (psel_v[0])         w = 0;
      else if (psel_v[1])         w = 1;
      if (w >= 0) begin
        m_owner = w;
        m_age   = 1;
        m_addr  = paddr_v[w];
        m_wr    = pwrite_v[w];
        m_wd    = pwdata_v[w];
        m_st    = pwstrb_v[w];
      end
    end else if (m_age >= 2 && t_pready_v) begin
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_age++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [1:0] active = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_all();
    psel_v      = '0;
    penable_v   = '0;
    pwrite_v    = '0;
    t_pready_v  = 1'b0;
    t_prdata_v  = '0;
    t_pslverr_v = 1'b0;
    for (int k = 0; k < 2; k++) begin
      paddr_v[k]  = '0;
      pwdata_v[k] = '0;
      pwstrb_v[k] = '0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Random APB masters and fabric. A master keeps psel and payload stable
  // until it has seen its pready, then may start the next transfer at once.
  task automatic auto_cycles(input int n, input int p0, input int p1,
                             input int prdy, input int prst, input int stop_log);
    int pct[2];
    pct[0] = p0;
    pct[1] = p1;
    for (int c = 0; c < n; c++) begin
      step();
      rst_n = ($urandom_range(0, 999) >= prst);
      for (int k = 0; k < 2; k++) begin
        if (active[k] && dut_rdy[k]) active[k] = 1'b0;
        if (!active[k] && ($urandom_range(0, 99) < pct[k])) begin
          active[k]   = 1'b1;
          paddr_v[k]  = {2'($urandom_range(0, 3)), 32'($urandom)};
          pwrite_v[k] = 1'($urandom);
          pwdata_v[k] = $urandom;
          pwstrb_v[k] = 4'($urandom);
        end
        psel_v[k]    = active[k];
        penable_v[k] = 1'($urandom);
      end
      t_pready_v  = ($urandom_range(0, 99) < prdy);
      t_prdata_v  = $urandom;
      t_pslverr_v = 1'($urandom);
      if (stop_log > 0 && dut_log.size() >= stop_log) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    at_neg();
    check("rst_t_psel",    t_bus.psel,    1'b0);
    check("rst_t_penable", t_bus.penable, 1'b0);
    check("rst_t_paddr",   t_bus.paddr,   34'h0);
    check("rst_i0_pready", rdy_o[0],      1'b0);

    // 1: single i0 read, zero downstream wait states
    step();
    psel_v[0]   = 1'b1;
    paddr_v[0]  = 34'h0_8000_0010;
    pwrite_v[0] = 1'b0;
    t_pready_v  = 1'b1;
    t_prdata_v  = 32'hDEAD_BEEF;
    at_neg();
    check("t1_c1_t_psel", t_bus.psel, 1'b0);
    step();
    penable_v[0] = 1'b1;
    at_neg();
    check("t1_c2_t_psel",    t_bus.psel,    1'b1);
    check("t1_c2_t_penable", t_bus.penable, 1'b0);
    check("t1_c2_t_paddr",   t_bus.paddr,   34'h0_8000_0010);
    check("t1_c2_i0_pready", rdy_o[0],      1'b0);
    step();
    at_neg();
    check("t1_c3_t_penable", t_bus.penable, 1'b1);
    check("t1_c3_i0_pready", rdy_o[0],      1'b1);
    check("t1_c3_i0_prdata", rd_o[0],       32'hDEAD_BEEF);
    check("t1_c3_i1_pready", rdy_o[1],      1'b0);
    step();
    psel_v[0]    = 1'b0;
    penable_v[0] = 1'b0;
    at_neg();
    check("t1_c4_t_psel",    t_bus.psel, 1'b0);
    check("t1_c4_i0_pready", rdy_o[0],   1'b0);

    // 2: simultaneous requests from reset, both re-requesting continuously
    do_reset();
    active = '0;
    dut_log.delete();
    auto_cycles(60, 100, 100, 100, 0, 4);
    check("t2_count", (dut_log.size() >= 4), 1'b1);
    if (dut_log.size() >= 4) begin
      check("t2_grant0", dut_log[0], 0);
      check("t2_grant1", dut_log[1], 1);
      check("t2_grant2", dut_log[2], 0);
      check("t2_grant3", dut_log[3], 1);
    end

    // 3: i1 write held by five downstream wait states
    do_reset();
    step();
    psel_v[1]   = 1'b1;
    paddr_v[1]  = 34'h1_0000_0040;
    pwrite_v[1] = 1'b1;
    pwdata_v[1] = 32'h1234_5678;
    pwstrb_v[1] = 4'h3;
    at_neg();
    step();
    at_neg();
    check("t3_setup_t_pwrite", t_bus.pwrite, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      at_neg();
      check("t3_wait_t_paddr",   t_bus.paddr,   34'h1_0000_0040);
      check("t3_wait_t_pwdata",  t_bus.pwdata,  32'h1234_5678);
      check("t3_wait_t_pwstrb",  t_bus.pwstrb,  4'h3);
      check("t3_wait_t_penable", t_bus.penable, 1'b1);
      check("t3_wait_i1_pready", rdy_o[1],      1'b0);
    end
    step();
    t_pready_v = 1'b1;
    t_prdata_v = 32'h0BAD_F00D;
    at_neg();
    check("t3_done_i1_pready", rdy_o[1], 1'b1);
    check("t3_done_i0_pready", rdy_o[0], 1'b0);
    step();
    psel_v[1]  = 1'b0;
    t_pready_v = 1'b0;
    at_neg();
    check("t3_after_i1_pready", rdy_o[1], 1'b0);

    // 4: slave error returned with the completion
    step();
    psel_v[0]   = 1'b1;
    paddr_v[0]  = 34'h0_0000_0100;
    pwrite_v[0] = 1'b0;
    t_pready_v  = 1'b1;
    t_pslverr_v = 1'b1;
    t_prdata_v  = 32'hCAFE_F00D;
    at_neg();
    step();
    at_neg();
    step();
    at_neg();
    check("t4_i0_pready",  rdy_o[0], 1'b1);
    check("t4_i0_pslverr", err_o[0], 1'b1);
    check("t4_i1_pslverr", err_o[1], 1'b0);
    check("t4_i0_prdata",  rd_o[0],  32'hCAFE_F00D);
    step();
    psel_v[0]   = 1'b0;
    t_pready_v  = 1'b0;
    t_pslverr_v = 1'b0;

    // 5: reset during a stalled access, then a tie right after reset
    step();
    psel_v[0]  = 1'b1;
    paddr_v[0] = 34'h0_0000_0200;
    at_neg();
    step();
    at_neg();
    step();
    at_neg();
    check("t5_access_t_penable", t_bus.penable, 1'b1);
    step();
    rst_n = 1'b0;
    at_neg();
    check("t5_inrst_t_psel",    t_bus.psel, 1'b0);
    check("t5_inrst_i0_pready", rdy_o[0],   1'b0);
    step();
    rst_n       = 1'b1;
    psel_v[1]   = 1'b1;
    paddr_v[1]  = 34'h1_0000_0300;
    pwrite_v[1] = 1'b0;
    at_neg();
    check("t5_post_t_psel",    t_bus.psel,    1'b0);
    check("t5_post_t_penable", t_bus.penable, 1'b0);
    check("t5_post_i0_pready", rdy_o[0],      1'b0);
    check("t5_post_i1_pready", rdy_o[1],      1'b0);
    step();
    at_neg();
    check("t5_tie_t_psel",  t_bus.psel,  1'b1);
    check("t5_tie_t_paddr", t_bus.paddr, 34'h0_0000_0200);

    // Randomized traffic with occasional resets, checked by the model
    active = psel_v;
    auto_cycles(3000, 40, 40, 60, 3, 0);

    step();
    idle_all();
    active = '0;
    for (int i = 0; i < 8; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
